// File: rtl/alu_exec.sv
// Execute-stage ALU with an optional iterative multiply/divide unit.
// Single-cycle ops answer in one cycle; M-ops take XLEN+1 cycles.
module alu_exec #(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            opb5,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_MUL,
    OP_MULHU,
    OP_DIVU,
    OP_REMU,
    OP_ILL
  } op_t;

  state_t state, nxt;

  op_t dop, rop, mdop, op_q;
  logic mreq, is_mop, is_mul, take;

  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;

  logic [XLEN-1:0] hi, lo, opnd;
  logic [XLEN-1:0] hi_nx, lo_nx;
  logic [XLEN-1:0] m_add, m_res, rsub;
  logic [XLEN:0]   msum, dsh;
  logic            ge, div_q;
  logic [CW-1:0]   cnt;

  // Base-ISA decode for aluop 10
  always_comb begin
    rop = OP_ADD;
    unique case (funct3)
      3'b000: rop = (opb5 & funct7b5) ? OP_SUB : OP_ADD;
      3'b001: rop = OP_SLL;
      3'b010: rop = OP_SLT;
      3'b011: rop = OP_SLTU;
      3'b100: rop = OP_XOR;
      3'b101: rop = funct7b5 ? OP_SRA : OP_SRL;
      3'b110: rop = OP_OR;
      3'b111: rop = OP_AND;
    endcase
  end

  always_comb begin
    mdop = OP_ILL;
    if (MDU_EN) begin
      case (funct3)
        3'b000:  mdop = OP_MUL;
        3'b011:  mdop = OP_MULHU;
        3'b101:  mdop = OP_DIVU;
        3'b111:  mdop = OP_REMU;
        default: mdop = OP_ILL;
      endcase
    end
  end

  assign mreq = opb5 & funct7b0;

  always_comb begin
    dop = OP_ILL;
    unique case (1'b1)
      aluop == 2'b00:          dop = OP_ADD;
      aluop == 2'b01:          dop = OP_SUB;
      aluop == 2'b11:          dop = OP_SLT;
      (aluop == 2'b10) & mreq: dop = mdop;
      (aluop == 2'b10) & !mreq: dop = rop;
    endcase
  end

  assign is_mop = (dop == OP_MUL) | (dop == OP_MULHU)
                | (dop == OP_DIVU) | (dop == OP_REMU);
  assign is_mul = (dop == OP_MUL) | (dop == OP_MULHU);

  assign shamt = b[SW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (dop)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                          $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      default: alu_res = '0;
    endcase
  end

  // Shift-add multiply: {hi,lo} shifts right, lo starts as b
  assign m_add = lo[0] ? opnd : '0;
  assign msum  = {1'b0, hi} + {1'b0, m_add};

  // Restoring divide: {hi,lo} shifts left, lo starts as a
  assign dsh   = {hi, lo[XLEN-1]};
  assign ge    = dsh >= {1'b0, opnd};
  assign rsub  = dsh[XLEN-1:0] - opnd;
  assign div_q = ge;

  always_comb begin
    hi_nx = msum[XLEN:1];
    lo_nx = {msum[0], lo[XLEN-1:1]};
    if ((op_q == OP_DIVU) | (op_q == OP_REMU)) begin
      hi_nx = ge ? rsub : dsh[XLEN-1:0];
      lo_nx = {lo[XLEN-2:0], div_q};
    end
  end

  always_comb begin
    m_res = lo;
    unique case (op_q)
      OP_MULHU: m_res = hi;
      OP_REMU:  m_res = hi;
      default:  m_res = lo;
    endcase
  end

  assign take = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (take) nxt = is_mop ? CALC : HOLD;
      CALC: if (cnt == '0) nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (in_valid) nxt = is_mop ? CALC : HOLD;
          else          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      illegal <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      op_q    <= OP_ADD;
    end else if (take) begin
      if (is_mop) begin
        op_q    <= dop;
        cnt     <= CW'(XLEN);
        hi      <= '0;
        lo      <= is_mul ? b : a;
        opnd    <= is_mul ? a : b;
        illegal <= 1'b0;
      end else begin
        result  <= alu_res;
        illegal <= (dop == OP_ILL);
      end
    end else if (state == CALC) begin
      if (cnt != '0) begin
        hi  <= hi_nx;
        lo  <= lo_nx;
        cnt <= cnt - 1'b1;
      end else begin
        result <= m_res;
      end
    end
  end

  assign zero = (result == '0);

endmodule
